spi_master_ctrl: RTL



---
 rtl/spi_master_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/spi_master_ctrl.sv
// SPI-style host initiator: serialises 10-bit commands on MOSI inside one SS_n-low frame and,
// for rd_data commands, captures the returned byte from MISO. Single clock, no separate SCLK.
module spi_master_ctrl #(
  parameter int unsigned LEAD_CYC = 1,
  parameter int unsigned RD_WAIT  = 3,
  parameter int unsigned GAP_CYC  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [9:0] cmd_data,
  output logic       cmd_ready,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    StIdle, StLead, StHdr, StShift, StWait, StRecv, StGap
  } state_e;

  localparam logic [3:0] LeadLast    = 4'(LEAD_CYC - 1);
  localparam logic [3:0] WaitLast    = 4'(RD_WAIT - 1);
  localparam logic [3:0] GapLast     = 4'(GAP_CYC - 1);
  localparam logic [3:0] ShiftWrLast = 4'd10;
  localparam logic [3:0] ShiftRdLast = 4'd9;
  localparam logic [3:0] RecvLast    = 4'd7;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [9:0] sr_q, sr_d;
  logic [7:0] rsp_sr_q, rsp_sr_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       ss_n_q, ss_n_d;
  logic       mosi_q, mosi_d;
  logic       cmd_ready_q, cmd_ready_d;
  logic       busy_q, busy_d;
  logic [3:0] bit_idx;
  logic       accept;
  logic       rd_op;

  assign accept = cmd_valid & cmd_ready_q;
  assign rd_op  = sr_q[9] & sr_q[8];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StLead;
      StLead:  if (cnt_q == LeadLast) state_d = StHdr;
      StHdr:   state_d = StShift;
      StShift: begin
        if (rd_op && cnt_q == ShiftRdLast) state_d = StWait;
        else if (!rd_op && cnt_q == ShiftWrLast) state_d = StGap;
      end
      StWait:  if (cnt_q == WaitLast) state_d = StRecv;
      StRecv:  if (cnt_q == RecvLast) state_d = StGap;
      StGap:   if (cnt_q == GapLast) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Per-state cycle counter; saturates instead of wrapping.
    if (state_d != state_q) cnt_d = 4'd0;
    else if (cnt_q == 4'hf) cnt_d = cnt_q;
    else                    cnt_d = cnt_q + 4'd1;
  end

  // Next values of the registered outputs, decoded from the upcoming state
  always_comb begin
    ss_n_d      = 1'b1;
    mosi_d      = 1'b0;
    bit_idx     = 4'd9 - cnt_d;
    cmd_ready_d = (state_d == StIdle);
    busy_d      = (state_d != StIdle);
    sr_d        = accept ? cmd_data : sr_q;
    rsp_sr_d    = rsp_sr_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    unique case (state_d)
      StIdle, StGap: ss_n_d = 1'b1;
      StHdr: begin
        ss_n_d = 1'b0;
        mosi_d = sr_q[9];
      end
      StShift: begin
        ss_n_d = 1'b0;
        if (cnt_d <= 4'd9) mosi_d = sr_q[bit_idx];
      end
      default: ss_n_d = 1'b0;
    endcase
    if (state_q == StRecv) begin
      rsp_sr_d = {rsp_sr_q[6:0], MISO};
      if (cnt_q == RecvLast) begin
        rsp_data_d  = {rsp_sr_q[6:0], MISO};
        rsp_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      sr_q        <= 10'd0;
      rsp_sr_q    <= 8'd0;
      rsp_data_q  <= 8'd0;
      rsp_valid_q <= 1'b0;
    end else begin
      ss_n_q      <= ss_n_d;
      mosi_q      <= mosi_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      sr_q        <= sr_d;
      rsp_sr_q    <= rsp_sr_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign SS_n      = ss_n_q;
  assign MOSI      = mosi_q;
  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_valid = rsp_valid_q;

endmodule
